// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg -- pack-mode encodings and the lane-flag bundle for the add result stage
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [1:0] PACK_WORD    = 2'b00;
  localparam logic [1:0] PACK_HALF    = 2'b01;
  localparam logic [1:0] PACK_BYTE    = 2'b10;
  localparam logic [1:0] PACK_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  carry;
    logic [3:0]  zero;
    logic        illegal;
  } lane_flags_t;

  localparam lane_flags_t FLAGS_CLEAR = '{result: 32'd0, carry: 4'd0, zero: 4'd0, illegal: 1'b0};

endpackage
`default_nettype wire

// File: rtl/add_lane_flags.sv
`default_nettype none
// ============================================================================
// add_lane_flags -- combinational packed add with per-lane carry and zero flags
// Revision: 1.0
// ============================================================================
module add_lane_flags
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  pack_mode,
  output lane_flags_t flags
);

  logic [32:0] word_sum;
  logic [16:0] half_lo_sum;
  logic [16:0] half_hi_sum;
  logic [8:0]  byte_sum [4];

  assign word_sum    = {1'b0, a} + {1'b0, b};
  assign half_lo_sum = {1'b0, a[15:0]}  + {1'b0, b[15:0]};
  assign half_hi_sum = {1'b0, a[31:16]} + {1'b0, b[31:16]};

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_byte
      assign byte_sum[i] = {1'b0, a[8*i+7:8*i]} + {1'b0, b[8*i+7:8*i]};
    end
  endgenerate

  always_comb begin
    flags = FLAGS_CLEAR;
    case (pack_mode)
      PACK_WORD: begin
        flags.result = word_sum[31:0];
        flags.carry  = {word_sum[32], 3'b000};
        flags.zero   = {4{word_sum[31:0] == 32'd0}};
      end
      PACK_HALF: begin
        flags.result = {half_hi_sum[15:0], half_lo_sum[15:0]};
        flags.carry  = {half_hi_sum[16], 1'b0, half_lo_sum[16], 1'b0};
        flags.zero   = {{2{half_hi_sum[15:0] == 16'd0}}, {2{half_lo_sum[15:0] == 16'd0}}};
      end
      PACK_BYTE: begin
        flags.result = {byte_sum[3][7:0], byte_sum[2][7:0], byte_sum[1][7:0], byte_sum[0][7:0]};
        flags.carry  = {byte_sum[3][8], byte_sum[2][8], byte_sum[1][8], byte_sum[0][8]};
        flags.zero   = {byte_sum[3][7:0] == 8'd0, byte_sum[2][7:0] == 8'd0,
                        byte_sum[1][7:0] == 8'd0, byte_sum[0][7:0] == 8'd0};
      end
      default: begin
        flags.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/add_result_stage.sv
`default_nettype none
// ============================================================================
// add_result_stage -- packed-add result stage behind a 2-entry skid buffer
// Revision: 1.0
// ============================================================================
module add_result_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_pack_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_carry,
  output logic [3:0]       out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  lane_flags_t      new_flags;
  lane_flags_t      main_flags;
  lane_flags_t      skid_flags;
  logic [TAG_W-1:0] main_tag;
  logic [TAG_W-1:0] skid_tag;
  logic             in_xfer;
  logic             out_xfer;

  add_lane_flags u_lane_flags (
    .a         (in_a),
    .b         (in_b),
    .pack_mode (in_pack_mode),
    .flags     (new_flags)
  );

  // Both handshakes depend on registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      main_flags <= FLAGS_CLEAR;
      skid_flags <= FLAGS_CLEAR;
      main_tag   <= '0;
      skid_tag   <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_flags <= new_flags;
            main_tag   <= in_tag;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_flags <= new_flags;
            main_tag   <= in_tag;
          end else if (in_xfer) begin
            skid_flags <= new_flags;
            skid_tag   <= in_tag;
            state      <= ST_FULL;
          end else if (out_xfer) begin
            state      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_flags <= skid_flags;
            main_tag   <= skid_tag;
            state      <= ST_ONE;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_result  = main_flags.result;
  assign out_carry   = main_flags.carry;
  assign out_zero    = main_flags.zero;
  assign out_illegal = main_flags.illegal;
  assign out_tag     = main_tag;

endmodule
`default_nettype wire
